// File: rtl/histogram_peak_reader_pkg.sv
// Shared types and widths for the histogram peak reader and its axis trackers.
package histogram_peak_reader_pkg;

    localparam int unsigned BIN_W   = 8;
    localparam int unsigned TOTAL_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StStream,
        StClear,
        StWaitClr,
        StDone
    } state_t;

endpackage

// File: rtl/histogram_peak_reader_if.sv
// Link between the peak reader (master) and the histogram block (slave).
interface histogram_peak_reader_if;
    import histogram_peak_reader_pkg::*;

    logic             read_histogram;
    logic             clear_histogram;
    logic [BIN_W-1:0] x_bin;
    logic [BIN_W-1:0] y_bin;
    logic             x_valid;
    logic             y_valid;
    logic             histogram_cleared;

    modport master (
        output read_histogram,
        output clear_histogram,
        input  x_bin,
        input  y_bin,
        input  x_valid,
        input  y_valid,
        input  histogram_cleared
    );

    modport slave (
        input  read_histogram,
        input  clear_histogram,
        output x_bin,
        output y_bin,
        output x_valid,
        output y_valid,
        output histogram_cleared
    );

endinterface

// File: rtl/histogram_peak_reader_axis_peak_tracker.sv
// Per-axis beat counter, running maximum, first-index argmax and bin-count total.
module axis_peak_tracker
    import histogram_peak_reader_pkg::*;
#(
    parameter int unsigned NUM_BINS = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               accept,
    input  logic               valid,
    input  logic [BIN_W-1:0]   bin,
    output logic               full_next,
    output logic               stray,
    output logic [BIN_W-1:0]   peak_idx,
    output logic [BIN_W-1:0]   peak_val,
    output logic [TOTAL_W-1:0] total
);

    localparam int unsigned CNT_W = $clog2(NUM_BINS) + 1;

    logic [CNT_W-1:0]   cnt_q;
    logic [BIN_W-1:0]   max_q;
    logic [BIN_W-1:0]   idx_q;
    logic [TOTAL_W-1:0] total_q;
    logic               full;
    logic               take;

    assign full      = (cnt_q == CNT_W'(NUM_BINS));
    assign take      = accept && valid && !full;
    // Completion including a beat landing this cycle, so the FSM can leave STREAM without a bubble.
    assign full_next = full || (take && (cnt_q == CNT_W'(NUM_BINS - 1)));
    assign stray     = valid && !take;

    always_ff @(posedge clk) begin
        if (reset || start) begin
            cnt_q   <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            total_q <= '0;
        end else if (take) begin
            cnt_q   <= cnt_q + CNT_W'(1);
            total_q <= total_q + TOTAL_W'(bin);
            // Strict compare keeps the lowest index on ties; bin 0 always seeds the maximum.
            if ((cnt_q == '0) || (bin > max_q)) begin
                max_q <= bin;
                idx_q <= BIN_W'(cnt_q);
            end
        end
    end

    assign peak_idx = idx_q;
    assign peak_val = max_q;
    assign total    = total_q;

endmodule

// File: rtl/histogram_peak_reader.sv
// Reads both histogram axes after each frame, finds peaks and totals, then clears the histogram.
module histogram_peak_reader
    import histogram_peak_reader_pkg::*;
#(
    parameter int unsigned NUM_BINS    = 256,
    parameter int unsigned CLR_TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_done,
    input  logic [BIN_W-1:0]             min_peak,
    histogram_peak_reader_if.master      hist,
    output logic [BIN_W-1:0]             x_peak_idx,
    output logic [BIN_W-1:0]             y_peak_idx,
    output logic [BIN_W-1:0]             x_peak_val,
    output logic [BIN_W-1:0]             y_peak_val,
    output logic [TOTAL_W-1:0]           x_total,
    output logic [TOTAL_W-1:0]           y_total,
    output logic                         target_found,
    output logic                         result_valid,
    output logic                         busy,
    output logic                         proto_err,
    output logic                         clr_timeout
);

    localparam int unsigned TMO_W = $clog2(CLR_TIMEOUT + 1);

    state_t             state_q;
    state_t             state_d;
    logic [TMO_W-1:0]   clr_cnt_q;
    logic [TMO_W-1:0]   clr_cnt_d;
    logic               set_timeout;
    logic               load;

    logic               x_full_next;
    logic               y_full_next;
    logic               x_stray;
    logic               y_stray;
    logic [BIN_W-1:0]   x_idx;
    logic [BIN_W-1:0]   y_idx;
    logic [BIN_W-1:0]   x_val;
    logic [BIN_W-1:0]   y_val;
    logic [TOTAL_W-1:0] x_sum;
    logic [TOTAL_W-1:0] y_sum;

    axis_peak_tracker #(
        .NUM_BINS (NUM_BINS)
    ) u_x_trk (
        .clk       (clk),
        .reset     (reset),
        .start     (state_q == StReq),
        .accept    (state_q == StStream),
        .valid     (hist.x_valid),
        .bin       (hist.x_bin),
        .full_next (x_full_next),
        .stray     (x_stray),
        .peak_idx  (x_idx),
        .peak_val  (x_val),
        .total     (x_sum)
    );

    axis_peak_tracker #(
        .NUM_BINS (NUM_BINS)
    ) u_y_trk (
        .clk       (clk),
        .reset     (reset),
        .start     (state_q == StReq),
        .accept    (state_q == StStream),
        .valid     (hist.y_valid),
        .bin       (hist.y_bin),
        .full_next (y_full_next),
        .stray     (y_stray),
        .peak_idx  (y_idx),
        .peak_val  (y_val),
        .total     (y_sum)
    );

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        set_timeout = 1'b0;
        unique case (state_q)
            StIdle:    if (frame_done) state_d = StReq;
            StReq:     state_d = StStream;
            StStream:  if (x_full_next && y_full_next) state_d = StClear;
            StClear: begin
                clr_cnt_d = '0;
                state_d   = StWaitClr;
            end
            StWaitClr: begin
                if (hist.histogram_cleared) begin
                    state_d = StDone;
                end else if (clr_cnt_q == TMO_W'(CLR_TIMEOUT - 1)) begin
                    state_d     = StDone;
                    set_timeout = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + TMO_W'(1);
                end
            end
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Results are captured on entry to DONE so they are already stable during the pulse.
    assign load = (state_q == StWaitClr) && (state_d == StDone);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            clr_cnt_q    <= '0;
            proto_err    <= 1'b0;
            clr_timeout  <= 1'b0;
            x_peak_idx   <= '0;
            y_peak_idx   <= '0;
            x_peak_val   <= '0;
            y_peak_val   <= '0;
            x_total      <= '0;
            y_total      <= '0;
            target_found <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            if (x_stray || y_stray) proto_err <= 1'b1;
            if (set_timeout) clr_timeout <= 1'b1;
            if (load) begin
                x_peak_idx   <= x_idx;
                y_peak_idx   <= y_idx;
                x_peak_val   <= x_val;
                y_peak_val   <= y_val;
                x_total      <= x_sum;
                y_total      <= y_sum;
                target_found <= (x_val >= min_peak) && (y_val >= min_peak);
            end
        end
    end

    assign result_valid         = (state_q == StDone);
    assign busy                 = (state_q != StIdle);
    assign hist.read_histogram  = (state_q == StReq);
    assign hist.clear_histogram = (state_q == StClear);

endmodule
